// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, RAM status and arbiter state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, ERR} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction and data accesses onto a single RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      ihit,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dhit,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      mem_err
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  arb_state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [CW-1:0] wait_q, wait_d;
  logic gi, req;
  // next state, wait counter and RAM/CPU outputs; both grant states share one path keyed on gi
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    gi       = state_q == GRANT_I;
    req      = gi ? iREN : (dREN | dWEN);
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    mem_err  = state_q == ERR;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if ((dREN | dWEN) && !(iREN && last_d_q)) state_d = GRANT_D;
        else if (iREN) state_d = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        ramREN   = gi | (dREN & ~dWEN);
        ramWEN   = ~gi & dWEN;
        ramaddr  = gi ? iaddr : daddr;
        ramstore = gi ? '0 : dstore;
        if (ramstate == ERROR) state_d = ERR;
        else if (!req) state_d = IDLE;
        else if (ramstate == ACCESS) begin
          ihit    = gi;
          dhit    = ~gi;
          iload   = gi ? ramload : '0;
          dload   = (~gi & ~dWEN) ? ramload : '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
          if (wait_d == CW'(WAIT_LIMIT)) state_d = ERR;
        end
      end
      default: ;
    endcase
    last_d_d = dhit ? 1'b1 : ihit ? 1'b0 : last_d_q;
  end
  // state, fairness flag and wait counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wait_q   <= wait_d;
    end
  end
endmodule
